ifetch_byte_buffer: RTL and testbench

Upstream companion to the SEQ fetch stage: accepts a PC, reads the instruction bytes one at a time from a byte-wide instruction memory, and presents an assembled 10-byte window (Byte0 + Byte1..9) with a valid/ready handshake. The instruction length is computed from the icode in byte 0, so a 1-, 2-, 9- or 10-byte instruction costs only that many memory reads. It also reports out-of-range fetches (imem_error) and invalid icodes to the fetch/status logic.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/instr_len_decode.sv | 27 ++
 rtl/ifetch_byte_buffer.sv | 167 ++++++++++++++++
 tb/tb_ifetch_byte_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 fetch definitions: icode values, instruction window size and
// the fetch-buffer FSM state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int INSTR_MAX_BYTES = 10;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_WAIT = 2'd2;
    localparam fetch_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational icode -> instruction length decoder, shared with the
// fetch stage. Unknown icodes report length 1 and instr_valid=0.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       instr_valid
);

    // Length lookup by instruction class
    always_comb begin
        len         = 4'd1;
        instr_valid = 1'b1;
        case (icode)
            IHALT, INOP, IRET:            len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: len = 4'd2;
            IJXX, ICALL:                  len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:    len = 4'd10;
            default: begin
                len         = 4'd1;
                instr_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ifetch_byte_buffer.sv
// Byte-serial instruction fetcher: reads only as many bytes as the icode
// needs from a byte-wide memory and presents a 10-byte window.
module ifetch_byte_buffer
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 1024
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] out_bytes,
    output logic [63:0] out_pc,
    output logic [3:0]  out_len,
    output logic        instr_valid,
    output logic        imem_error
);

    localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_SIZE);
    localparam int          BUF_W      = INSTR_MAX_BYTES * 8;

    fetch_state_t     state_r;
    logic [3:0]       idx_r;
    logic [3:0]       len_r;
    logic [63:0]      pc_r;
    logic [63:0]      addr_r;
    logic             carry_r;
    logic [BUF_W-1:0] buf_r;
    logic             out_valid_r;
    logic             instr_valid_r;
    logic             imem_error_r;
    logic             discard_r;

    logic             range_err_s;
    logic             req_s;
    logic             outstanding_s;
    logic             last_byte_s;
    logic [3:0]       dec_len_s;
    logic             dec_valid_s;
    logic [3:0]       eff_len_s;
    logic [63:0]      addr_inc_s;
    logic             addr_carry_s;

    instr_len_decode u_len_decode (
        .icode       (mem_rdata[7:4]),
        .len         (dec_len_s),
        .instr_valid (dec_valid_s)
    );

    // Address range check, request decode and end-of-instruction detection
    always_comb begin
        range_err_s   = carry_r || (addr_r >= IMEM_LIMIT);
        req_s         = (state_r == ST_REQ) && !range_err_s;
        outstanding_s = req_s || ((state_r == ST_WAIT) && !mem_rvalid);
        {addr_carry_s, addr_inc_s} = {1'b0, addr_r} + 65'd1;
        if (idx_r == 4'd0) begin
            eff_len_s = dec_len_s;
        end else begin
            eff_len_s = len_r;
        end
        last_byte_s = ((idx_r + 4'd1) == eff_len_s);
    end

    // Discard flag: swallows the one response still in flight after a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_r <= 1'b0;
        end else begin
            discard_r <= (discard_r && !mem_rvalid) || (flush && outstanding_s);
        end
    end

    // Fetch FSM, byte buffer and presented-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= 4'd0;
            len_r         <= 4'd0;
            pc_r          <= 64'd0;
            addr_r        <= 64'd0;
            carry_r       <= 1'b0;
            buf_r         <= '0;
            out_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
            imem_error_r  <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pc_valid && !discard_r) begin
                        pc_r          <= pc_in;
                        addr_r        <= pc_in;
                        carry_r       <= 1'b0;
                        buf_r         <= '0;
                        idx_r         <= 4'd0;
                        len_r         <= 4'(INSTR_MAX_BYTES);
                        instr_valid_r <= 1'b0;
                        imem_error_r  <= 1'b0;
                        state_r       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (range_err_s) begin
                        imem_error_r <= 1'b1;
                        // No icode seen yet, so the length is unknown: report 1
                        if (idx_r == 4'd0) begin
                            len_r <= 4'd1;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        for (int i = 0; i < INSTR_MAX_BYTES; i++) begin
                            if (idx_r == 4'(i)) begin
                                buf_r[i*8 +: 8] <= mem_rdata;
                            end
                        end
                        if (idx_r == 4'd0) begin
                            len_r         <= dec_len_s;
                            instr_valid_r <= dec_valid_s;
                        end
                        idx_r   <= idx_r + 4'd1;
                        addr_r  <= addr_inc_s;
                        carry_r <= carry_r | addr_carry_s;
                        state_r <= last_byte_s ? ST_DONE : ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_ready    = (state_r == ST_IDLE) && !discard_r;
    assign mem_req     = req_s;
    assign mem_addr    = addr_r;
    assign out_valid   = out_valid_r;
    assign out_bytes   = buf_r;
    assign out_pc      = pc_r;
    assign out_len     = len_r;
    assign instr_valid = instr_valid_r;
    assign imem_error  = imem_error_r;

endmodule

// File: tb/tb_ifetch_byte_buffer.sv
// Scoreboard bench for ifetch_byte_buffer: a byte memory with programmable
// latency, expected windows built from the memory image at issue time.
module tb_ifetch_byte_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_in = 64'd0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_rvalid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [79:0] out_bytes;
    logic [63:0] out_pc;
    logic [3:0]  out_len;
    logic        instr_valid;
    logic        imem_error;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  len;
        logic [79:0] bytes;
        logic        valid;
        logic        err;
        int          nreq;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [7:0]  mem [0:1023];
    logic [63:0] req_q [$];
    exp_t        sb_q [$];
    logic        pend = 1'b0;
    int          rem = 0;
    logic [63:0] rsp_addr = 64'd0;

    ifetch_byte_buffer #(.IMEM_SIZE(1024)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes),
        .out_pc(out_pc), .out_len(out_len), .instr_valid(instr_valid),
        .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: answers each request lat cycles later, logs addresses
    always @(negedge clk) begin
        if (pend && rem == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= (rsp_addr < 64'd1024) ? mem[rsp_addr[9:0]] : 8'h00;
            pend       <= 1'b0;
        end else begin
            mem_rvalid <= 1'b0;
            if (pend) rem <= rem - 1;
        end
        if (mem_req) begin
            pend     <= 1'b1;
            rem      <= lat;
            rsp_addr <= mem_addr;
            req_q.push_back(mem_addr);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] icode_info(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return {1'b1, 4'd1};
            4'h2, 4'h6, 4'hA, 4'hB: return {1'b1, 4'd2};
            4'h7, 4'h8:             return {1'b1, 4'd9};
            4'h3, 4'h4, 4'h5:       return {1'b1, 4'd10};
            default:                return {1'b0, 4'd1};
        endcase
    endfunction

    function automatic exp_t model(input logic [63:0] pc);
        exp_t        e;
        logic [64:0] a;
        logic [7:0]  b;
        logic [4:0]  info;
        bit          stop;
        e.pc = pc; e.len = 4'd10; e.bytes = 80'd0; e.valid = 1'b0; e.err = 1'b0; e.nreq = 0;
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!stop && i < int'(e.len)) begin
                a = {1'b0, pc} + 65'(i);
                if (a >= 65'd1024) begin
                    e.err = 1'b1;
                    if (i == 0) e.len = 4'd1;
                    stop = 1'b1;
                end else begin
                    b = mem[a[9:0]];
                    e.bytes[i*8 +: 8] = b;
                    e.nreq++;
                    if (i == 0) begin
                        info    = icode_info(b[7:4]);
                        e.len   = info[3:0];
                        e.valid = info[4];
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_fetch(input string name, input logic [63:0] pc, input int hold);
        exp_t        e;
        int          a_cyc, exp_lat, k;
        bit          ok, addr_bad;
        logic [227:0] exp_vec, got_vec;
        for (k = 0; k < 50 && !pc_ready; k++) tick();
        checks++;
        if (!pc_ready) begin
            failures++;
            $display("FAIL %s pc_ready_wait got=%0b exp=1", name, pc_ready);
            return;
        end
        req_q.delete();
        pc_in = pc; pc_valid = 1'b1;
        sb_q.push_back(model(pc));
        tick();
        pc_valid = 1'b0;
        a_cyc = cyc;
        ok = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s out_valid_timeout got=0 exp=1", name);
            flush = 1'b1; tick(); flush = 1'b0; tick();
            return;
        end
        exp_lat = e.nreq * (1 + lat) + (e.err ? 2 : 1);
        if (cyc - a_cyc !== exp_lat) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, cyc - a_cyc, exp_lat);
        end
        exp_vec = {1'b1, 1'b0, e.pc, e.len, e.bytes, e.valid, e.err};
        got_vec = {out_valid, pc_ready, out_pc, out_len, out_bytes, instr_valid, imem_error};
        checks++;
        if (out_pc !== e.pc) begin
            failures++;
            $display("FAIL %s out_pc got=%h exp=%h", name, out_pc, e.pc);
        end
        checks++;
        if (out_len !== e.len) begin
            failures++;
            $display("FAIL %s out_len got=%0d exp=%0d", name, out_len, e.len);
        end
        checks++;
        if (out_bytes !== e.bytes) begin
            failures++;
            $display("FAIL %s out_bytes got=%h exp=%h", name, out_bytes, e.bytes);
        end
        checks++;
        if ({instr_valid, imem_error} !== {e.valid, e.err}) begin
            failures++;
            $display("FAIL %s valid_err got=%b%b exp=%b%b", name, instr_valid, imem_error, e.valid, e.err);
        end
        checks++;
        if (pc_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s pc_ready_in_done got=%b exp=0", name, pc_ready);
        end
        addr_bad = (req_q.size() != e.nreq);
        for (int i = 0; i < req_q.size() && i < e.nreq; i++)
            if (req_q[i] !== pc + 64'(i)) addr_bad = 1'b1;
        checks++;
        if (addr_bad) begin
            failures++;
            $display("FAIL %s mem_req_seq got_count=%0d exp_count=%0d", name, req_q.size(), e.nreq);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            got_vec = {out_valid, pc_ready, out_pc, out_len, out_bytes, instr_valid, imem_error};
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL %s hold_stable cycle=%0d got=%h exp=%h", name, h, got_vec, exp_vec);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, pc_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s after_handshake got=%b%b exp=01", name, out_valid, pc_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (pc_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_pc_ready got=%b exp=1", pc_ready);
        end
        checks++;
        if ({out_valid, mem_req, mem_addr, out_bytes, out_pc, out_len, instr_valid, imem_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b %h %h %h %h %b%b exp=all_zero", out_valid, mem_req,
                     mem_addr, out_bytes, out_pc, out_len, instr_valid, imem_error);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        int n;
        lat = 4;
        req_q.delete();
        pc_in = 64'h80; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({pc_ready, out_valid, mem_req} !== 3'b000) begin
            failures++;
            $display("FAIL flush_idle got=%b%b%b exp=000", pc_ready, out_valid, mem_req);
        end
        for (n = 0; n < 20 && !pc_ready; n++) tick();
        checks++;
        if (n !== lat - 1) begin
            failures++;
            $display("FAIL flush_discard_wait got=%0d exp=%0d", n, lat - 1);
        end
        checks++;
        if (req_q.size() !== 1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_single_req got=%0d exp=1", req_q.size());
        end
        lat = 1;
        run_fetch("after_flush", 64'h90, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]     = 8'h10; mem[1] = 8'h77;
        mem[32'h20] = 8'h30; mem[32'h21] = 8'hF3; mem[32'h22] = 8'h0A;
        mem[32'h40] = 8'hE0; mem[32'h41] = 8'h55;
        mem[32'h50] = 8'h20; mem[32'h51] = 8'h12;
        mem[32'h60] = 8'h70;
        for (int i = 1; i < 9; i++) mem[32'h60 + i] = 8'(8'hA0 + i);
        mem[32'h80] = 8'h10;
        mem[32'h90] = 8'h61; mem[32'h91] = 8'h23;
        mem[1023]   = 8'h30;

        test_reset();
        run_fetch("nop", 64'h0, 0);
        run_fetch("irmovq", 64'h20, 0);
        run_fetch("range_err", 64'd1023, 0);
        run_fetch("err_idx0", 64'd2000, 0);
        run_fetch("err_top", 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_fetch("bad_icode", 64'h40, 0);
        lat = 3;
        run_fetch("jmp_lat3", 64'h60, 0);
        lat = 1;
        test_flush();
        run_fetch("backpressure", 64'h50, 5);
        run_fetch("b2b_first", 64'h90, 0);
        run_fetch("b2b_second", 64'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
